// File: rtl/snake_head.sv
// Snake-head controller: steers and steps the head square, flags head pixels for the
// pixel mux, detects apple overlap during scan-out and keeps score.
// Optional build macro SNAKE_WRAP_EN: walls wrap around instead of ending the game.
module snake_head #(
  parameter int unsigned STEP     = 10,
  parameter int unsigned MOVE_DIV = 6,
  parameter int unsigned START_X  = 200,
  parameter int unsigned START_Y  = 300,
  parameter int unsigned X_MIN    = 20,
  parameter int unsigned X_MAX    = 790,
  parameter int unsigned Y_MIN    = 20,
  parameter int unsigned Y_MAX    = 590
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [9:0] pixel_row,
  input  logic [9:0] pixel_column,
  input  logic       vert_sync,
  input  logic       is_apple,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  output logic       got_apple,
  output logic       is_head,
  output logic [9:0] head_x,
  output logic [9:0] head_y,
  output logic [7:0] score,
  output logic       game_over
);

  typedef enum logic [1:0] {StIdle, StRun, StOver} state_e;
  typedef enum logic [1:0] {DirUp, DirDown, DirLeft, DirRight} dir_e;

  // 11-bit copies so bound checks never wrap
  localparam logic [10:0] StepE = 11'(STEP);
  localparam logic [10:0] XMinE = 11'(X_MIN);
  localparam logic [10:0] XMaxE = 11'(X_MAX);
  localparam logic [10:0] YMinE = 11'(Y_MIN);
  localparam logic [10:0] YMaxE = 11'(Y_MAX);
  localparam logic [9:0]  Step10 = 10'(STEP);
  localparam logic [9:0]  XMin10 = 10'(X_MIN);
  localparam logic [9:0]  XMax10 = 10'(X_MAX);
  localparam logic [9:0]  YMin10 = 10'(Y_MIN);
  localparam logic [9:0]  YMax10 = 10'(Y_MAX);
  localparam logic [5:0]  CntLast = 6'(MOVE_DIV - 1);

  state_e     state_q, state_d;
  dir_e       dir_q, dir_d;
  dir_e       req_dir;
  logic       any_btn;
  logic       vsync_q, vsync_qq;
  logic       tick;
  logic [5:0] cnt_q, cnt_d;
  logic [9:0] head_x_q, head_y_q;
  logic [9:0] next_x, next_y;
  logic       wall, blocked;
  logic       step_due;
  logic       hit_q, hit_now, hit_frame;
  logic       got_q;
  logic [7:0] score_q;
  logic [10:0] col_e, row_e, hx_e, hy_e;

  function automatic dir_e reverse_of(input dir_e d);
    unique case (d)
      DirUp:    return DirDown;
      DirDown:  return DirUp;
      DirLeft:  return DirRight;
      default:  return DirLeft;
    endcase
  endfunction

  // Register vert_sync once, then detect its registered falling edge
  always_ff @(posedge clock) begin
    if (reset) begin
      vsync_q  <= 1'b1;
      vsync_qq <= 1'b1;
    end else begin
      vsync_q  <= vert_sync;
      vsync_qq <= vsync_q;
    end
  end

  assign tick = vsync_qq & ~vsync_q;

  // Head square membership of the current scan pixel
  always_comb begin
    col_e   = {1'b0, pixel_column};
    row_e   = {1'b0, pixel_row};
    hx_e    = {1'b0, head_x_q};
    hy_e    = {1'b0, head_y_q};
    is_head = (hx_e <= col_e + 11'd8) && (hx_e >= col_e) &&
              (hy_e <= row_e + 11'd8) && (hy_e >= row_e);
  end

  assign hit_now   = (state_q == StRun) && is_head && is_apple;
  assign hit_frame = hit_q | hit_now;

  // Button decode with fixed priority up > down > left > right
  always_comb begin
    any_btn = btn_up | btn_down | btn_left | btn_right;
    req_dir = DirRight;
    if (btn_up) begin
      req_dir = DirUp;
    end else if (btn_down) begin
      req_dir = DirDown;
    end else if (btn_left) begin
      req_dir = DirLeft;
    end
  end

  // Direction update; the reverse-request filter applies only while running
  always_comb begin
    dir_d = dir_q;
    if (any_btn) begin
      if (state_q == StIdle) begin
        dir_d = req_dir;
      end else if (state_q == StRun && req_dir != reverse_of(dir_q)) begin
        dir_d = req_dir;
      end
    end
  end

  // Frame counter divides ticks down to steps
  always_comb begin
    step_due = (state_q == StRun) && tick && (cnt_q == CntLast);
    cnt_d    = cnt_q;
    if (state_q == StRun && tick) begin
      cnt_d = (cnt_q == CntLast) ? 6'd0 : cnt_q + 6'd1;
    end
  end

  // Candidate next position; on a wall the target is the opposite edge (used only when wrapping)
  always_comb begin
    next_x = head_x_q;
    next_y = head_y_q;
    wall   = 1'b0;
    unique case (dir_q)
      DirUp: begin
        if (hy_e < YMinE + StepE) begin
          wall   = 1'b1;
          next_y = YMax10;
        end else begin
          next_y = head_y_q - Step10;
        end
      end
      DirDown: begin
        if (hy_e + StepE > YMaxE) begin
          wall   = 1'b1;
          next_y = YMin10;
        end else begin
          next_y = head_y_q + Step10;
        end
      end
      DirLeft: begin
        if (hx_e < XMinE + StepE) begin
          wall   = 1'b1;
          next_x = XMax10;
        end else begin
          next_x = head_x_q - Step10;
        end
      end
      default: begin
        if (hx_e + StepE > XMaxE) begin
          wall   = 1'b1;
          next_x = XMin10;
        end else begin
          next_x = head_x_q + Step10;
        end
      end
    endcase
  end

`ifdef SNAKE_WRAP_EN
  assign blocked = 1'b0;
  logic unused_wall;
  assign unused_wall = wall;
`else
  assign blocked = wall;
`endif

  // FSM state register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (any_btn) state_d = StRun;
      StRun:   if (step_due && blocked) state_d = StOver;
      StOver:  state_d = StOver;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    game_over = (state_q == StOver);
  end

  // Direction, frame counter and head position
  always_ff @(posedge clock) begin
    if (reset) begin
      dir_q    <= DirRight;
      cnt_q    <= 6'd0;
      head_x_q <= 10'(START_X);
      head_y_q <= 10'(START_Y);
    end else begin
      dir_q <= dir_d;
      cnt_q <= cnt_d;
      if (step_due && !blocked) begin
        head_x_q <= next_x;
        head_y_q <= next_y;
      end
    end
  end

  // Hit latch, one-frame got_apple pulse and saturating score
  always_ff @(posedge clock) begin
    if (reset) begin
      hit_q   <= 1'b0;
      got_q   <= 1'b0;
      score_q <= 8'd0;
    end else if (state_q == StOver) begin
      hit_q <= 1'b0;
      if (tick) got_q <= 1'b0;
    end else if (tick) begin
      got_q <= hit_frame;
      hit_q <= 1'b0;
      if (hit_frame && score_q != 8'hff) score_q <= score_q + 8'd1;
    end else if (hit_now) begin
      hit_q <= 1'b1;
    end
  end

  assign head_x    = head_x_q;
  assign head_y    = head_y_q;
  assign got_apple = got_q;
  assign score     = score_q;

endmodule

// File: tb/tb_snake_head.sv
// Scoreboard bench for snake_head: stimulus pushes expected snapshots, a monitor compares.
module tb_snake_head;

  logic       clock = 1'b0;
  logic       reset;
  logic [9:0] pixel_row, pixel_column;
  logic       vert_sync, is_apple;
  logic       btn_up, btn_down, btn_left, btn_right;
  logic       got_apple, is_head, game_over;
  logic [9:0] head_x, head_y;
  logic [7:0] score;

  always #5 clock = ~clock;

  snake_head dut (
    .clock        (clock),
    .reset        (reset),
    .pixel_row    (pixel_row),
    .pixel_column (pixel_column),
    .vert_sync    (vert_sync),
    .is_apple     (is_apple),
    .btn_up       (btn_up),
    .btn_down     (btn_down),
    .btn_left     (btn_left),
    .btn_right    (btn_right),
    .got_apple    (got_apple),
    .is_head      (is_head),
    .head_x       (head_x),
    .head_y       (head_y),
    .score        (score),
    .game_over    (game_over)
  );

  typedef struct {
    string      name;
    logic [9:0] x;
    logic [9:0] y;
    logic       got;
    logic [7:0] sc;
    logic       over;
    logic       chk_h;
    logic       h;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Square path used for the long scoring run: head position per direction block
  int pos_x [4] = '{200, 200, 190, 190};
  int pos_y [4] = '{300, 290, 290, 300};

  // Monitor: compare the DUT against the oldest expected snapshot
  exp_t e;
  always @(negedge clock) begin
    if (sb.size() != 0) begin
      e = sb.pop_front();
      n_cmp++;
      if (head_x !== e.x || head_y !== e.y || got_apple !== e.got || score !== e.sc ||
          game_over !== e.over || (e.chk_h && is_head !== e.h)) begin
        n_bad++;
        $display("FAIL %s: actual x=%0d y=%0d got=%b score=%0d over=%b head=%b, required x=%0d y=%0d got=%b score=%0d over=%b head=%b(chk=%b)",
                 e.name, head_x, head_y, got_apple, score, game_over, is_head,
                 e.x, e.y, e.got, e.sc, e.over, e.h, e.chk_h);
      end
    end
  end

  task automatic check(input string nm, input int x, input int y, input bit got, input int sc,
                       input bit over, input bit chk_h, input bit h);
    exp_t t;
    #2;
    t.name = nm; t.x = 10'(x); t.y = 10'(y); t.got = got; t.sc = 8'(sc);
    t.over = over; t.chk_h = chk_h; t.h = h;
    sb.push_back(t);
    @(negedge clock);
    @(negedge clock);
  endtask

  task automatic idle_inputs();
    pixel_row = 10'd0; pixel_column = 10'd0; is_apple = 1'b0;
  endtask

  // One short frame: vert_sync low in cycle 5, optional apple pixel in cycle 'at'
  task automatic frame(input bit hit, input int at, input int row, input int col);
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      vert_sync = (c == 5) ? 1'b0 : 1'b1;
      if (hit && c == at) begin
        pixel_row = 10'(row); pixel_column = 10'(col); is_apple = 1'b1;
      end else begin
        idle_inputs();
      end
    end
    @(negedge clock);
    vert_sync = 1'b1;
    idle_inputs();
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame(1'b0, 0, 0, 0);
  endtask

  task automatic press(input bit u, input bit d, input bit l, input bit r);
    @(negedge clock);
    btn_up = u; btn_down = d; btn_left = l; btn_right = r;
    @(negedge clock);
    btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0;
  endtask

  // Direction index order around the square: up, left, down, right
  task automatic press_dir(input int d);
    case (d)
      0: press(1, 0, 0, 0);
      1: press(0, 0, 1, 0);
      2: press(0, 1, 0, 0);
      default: press(0, 0, 0, 1);
    endcase
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; vert_sync = 1'b1;
    btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0;
    idle_inputs();
    do_reset();

    check("reset", 200, 300, 0, 0, 0, 0, 0);
    // is_head boundaries around head (200,300)
    pixel_row = 10'd300; pixel_column = 10'd200;
    check("head_exact", 200, 300, 0, 0, 0, 1, 1);
    pixel_column = 10'd191;
    check("head_col191", 200, 300, 0, 0, 0, 1, 0);
    pixel_column = 10'd192;
    check("head_col192", 200, 300, 0, 0, 0, 1, 1);
    pixel_column = 10'd201;
    check("head_col201", 200, 300, 0, 0, 0, 1, 0);
    pixel_column = 10'd200; pixel_row = 10'd291;
    check("head_row291", 200, 300, 0, 0, 0, 1, 0);
    pixel_row = 10'd292;
    check("head_row292", 200, 300, 0, 0, 0, 1, 1);
    idle_inputs();

    // Start moving right; a step every 6 frames
    press(0, 0, 0, 1);
    frames(5);
    check("run_f5", 200, 300, 0, 0, 0, 0, 0);
    frames(1);
    check("run_f6", 210, 300, 0, 0, 0, 0, 0);
    frames(6);
    check("run_f12", 220, 300, 0, 0, 0, 0, 0);

    // Apple hit mid-frame, then a hit on the tick cycle itself
    frame(1, 2, 300, 220);
    check("hit1", 220, 300, 1, 1, 0, 0, 0);
    frames(1);
    check("hit1_drop", 220, 300, 0, 1, 0, 0, 0);
    frame(1, 6, 300, 220);
    check("hit_on_tick", 220, 300, 1, 2, 0, 0, 0);
    frames(1);
    check("hit2_drop", 220, 300, 0, 2, 0, 0, 0);

    // Reverse request ignored; up beats left
    press(0, 0, 1, 0);
    frames(2);
    check("rev_ignored", 230, 300, 0, 2, 0, 0, 0);
    press(1, 0, 1, 0);
    frames(6);
    check("turn_up", 230, 290, 0, 2, 0, 0, 0);

    // Reset mid-run, then 256 consecutive hit frames around a small square
    do_reset();
    check("reset_midrun", 200, 300, 0, 0, 0, 0, 0);
    press(1, 0, 0, 0);
    for (int i = 0; i < 256; i++) begin
      frame(1, 2, pos_y[(i / 6) % 4], pos_x[(i / 6) % 4]);
      if (i == 253) check("score_254", 190, 290, 1, 254, 0, 0, 0);
      if (i == 254) check("score_255", 190, 290, 1, 255, 0, 0, 0);
      if (i == 255) check("score_sat", 190, 290, 1, 255, 0, 0, 0);
      if (i % 6 == 5) press_dir(((i / 6) + 1) % 4);
    end

    // Run right into the wall
    do_reset();
    press(0, 0, 0, 1);
    frames(348);
    check("near_wall", 780, 300, 0, 0, 0, 0, 0);
    frames(6);
    check("at_xmax", 790, 300, 0, 0, 0, 0, 0);
    frames(5);
    frame(1, 2, 300, 790);
`ifdef SNAKE_WRAP_EN
    check("wrap_x", 20, 300, 1, 1, 0, 0, 0);
    frames(1);
    check("wrap_drop", 20, 300, 0, 1, 0, 0, 0);
    frame(1, 2, 300, 20);
    check("wrap_hit", 20, 300, 1, 2, 0, 0, 0);
`else
    check("wall_over", 790, 300, 1, 1, 1, 0, 0);
    frames(1);
    check("over_drop", 790, 300, 0, 1, 1, 0, 0);
    frame(1, 2, 300, 790);
    check("over_hit", 790, 300, 0, 1, 1, 0, 0);
`endif
    do_reset();
    check("reset_after", 200, 300, 0, 0, 0, 0, 0);
    frames(6);
    check("idle_static", 200, 300, 0, 0, 0, 0, 0);

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clock);
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: actual %0d pending, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual timeout, required finish");
    $fatal(1, "timeout");
  end

endmodule
